// File: rtl/ssd_scan_ctrl.sv
// Purpose  : 8-digit seven-segment scan scheduler; snapshots hex or BCD source per frame and multiplexes digits.
// Latency  : an/cc/digit registered together; outputs track the digit update with 0 extra cycles.
// Backpr.  : none; source switches only at frame end, with one blank guard slot between sources.
// Ports    : clk/rst (async active-low); hex_val/bcd_val 32b values with their enables; sel picks the source;
//            blank_lz enables leading-zero blanking; an/cc active-low pins; digit/src status; frame_done pulse.
module ssd_scan_ctrl #(
    parameter int CLK_DIV = 100000
) (
    input  logic        ssd_scan_ctrl_clk,
    input  logic        ssd_scan_ctrl_rst,
    input  logic [31:0] ssd_scan_ctrl_hex_val,
    input  logic [31:0] ssd_scan_ctrl_bcd_val,
    input  logic        ssd_scan_ctrl_hex_en,
    input  logic        ssd_scan_ctrl_bcd_en,
    input  logic        ssd_scan_ctrl_sel,
    input  logic        ssd_scan_ctrl_blank_lz,
    output logic [7:0]  ssd_scan_ctrl_an,
    output logic [6:0]  ssd_scan_ctrl_cc,
    output logic [2:0]  ssd_scan_ctrl_digit,
    output logic        ssd_scan_ctrl_src,
    output logic        ssd_scan_ctrl_frame_done
);

    localparam int            CW      = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV);

    typedef enum logic [1:0] {ST_BLANK, ST_SCAN, ST_GUARD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic          src_q, src_d;
    logic [31:0]   snap_q, snap_d;
    logic          frame_en_q, frame_en_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    cc_q, cc_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          load;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          lz_blank;
    logic          lit;
    logic [6:0]    glyph;

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        src_d        = src_q;
        snap_d       = snap_q;
        frame_en_d   = frame_en_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        tick  = (cnt_q == DIV_MAX);
        cnt_d = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            ST_BLANK: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    digit_d = 3'd0;
                    load    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (tick) begin
                    if (digit_q != 3'd7) begin
                        digit_d = digit_q + 3'd1;
                    end else begin
                        frame_done_d = 1'b1;
                        digit_d      = 3'd0;
                        // Same source: start the next frame directly; otherwise insert a blank slot.
                        if (ssd_scan_ctrl_sel == src_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_GUARD;
                        end
                    end
                end
            end
            ST_GUARD: begin
                digit_d = 3'd0;
                if (tick) begin
                    state_d = ST_SCAN;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                digit_d = 3'd0;
            end
        endcase

        if (load) begin
            src_d      = ssd_scan_ctrl_sel;
            snap_d     = ssd_scan_ctrl_sel ? ssd_scan_ctrl_bcd_val : ssd_scan_ctrl_hex_val;
            frame_en_d = ssd_scan_ctrl_sel ? ssd_scan_ctrl_bcd_en  : ssd_scan_ctrl_hex_en;
        end

        // Outputs are decoded from next-state values so an/cc move on the same edge as digit.
        nib      = snap_d[{digit_d, 2'b00} +: 4];
        upper    = snap_d >> {digit_d, 2'b00};
        lz_blank = ssd_scan_ctrl_blank_lz && (digit_d != 3'd0) && (upper == 32'd0);
        lit      = (state_d == ST_SCAN) && frame_en_d && !lz_blank;

        if (src_d && (nib > 4'd9)) begin
            glyph = 7'h3F;
        end else begin
            glyph = hex_glyph(nib);
        end

        an_d = lit ? ~(8'd1 << digit_d) : 8'hFF;
        cc_d = lit ? glyph : 7'h7F;
    end

    always_ff @(posedge ssd_scan_ctrl_clk or negedge ssd_scan_ctrl_rst) begin
        if (!ssd_scan_ctrl_rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= 3'd0;
            src_q        <= 1'b0;
            snap_q       <= 32'd0;
            frame_en_q   <= 1'b0;
            an_q         <= 8'hFF;
            cc_q         <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            src_q        <= src_d;
            snap_q       <= snap_d;
            frame_en_q   <= frame_en_d;
            an_q         <= an_d;
            cc_q         <= cc_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ssd_scan_ctrl_an         = an_q;
    assign ssd_scan_ctrl_cc         = cc_q;
    assign ssd_scan_ctrl_digit      = digit_q;
    assign ssd_scan_ctrl_src        = src_q;
    assign ssd_scan_ctrl_frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Purpose  : directed self-checking bench for ssd_scan_ctrl (CLK_DIV = 0 and CLK_DIV = 3 instances).
// Latency  : inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpr.  : none.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst4_n = 1'b0;
    logic [31:0] hex_val = 32'h89AB_CDEF;
    logic [31:0] bcd_val = 32'h0;
    logic        hex_en = 1'b1;
    logic        bcd_en = 1'b0;
    logic        sel = 1'b0;
    logic        blank_lz = 1'b0;

    logic [7:0]  an,  an4;
    logic [6:0]  cc,  cc4;
    logic [2:0]  dig, dig4;
    logic        src, src4;
    logic        fd,  fd4;

    int tests = 0;
    int fails = 0;

    // Glyphs of 89AB_CDEF, digit 0 first (nibbles F,E,D,C,B,A,9,8).
    logic [6:0] exp_cc [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.CLK_DIV(0)) dut (
        .ssd_scan_ctrl_clk(clk), .ssd_scan_ctrl_rst(rst_n),
        .ssd_scan_ctrl_hex_val(hex_val), .ssd_scan_ctrl_bcd_val(bcd_val),
        .ssd_scan_ctrl_hex_en(hex_en), .ssd_scan_ctrl_bcd_en(bcd_en),
        .ssd_scan_ctrl_sel(sel), .ssd_scan_ctrl_blank_lz(blank_lz),
        .ssd_scan_ctrl_an(an), .ssd_scan_ctrl_cc(cc), .ssd_scan_ctrl_digit(dig),
        .ssd_scan_ctrl_src(src), .ssd_scan_ctrl_frame_done(fd)
    );

    ssd_scan_ctrl #(.CLK_DIV(3)) dut4 (
        .ssd_scan_ctrl_clk(clk), .ssd_scan_ctrl_rst(rst4_n),
        .ssd_scan_ctrl_hex_val(hex_val), .ssd_scan_ctrl_bcd_val(bcd_val),
        .ssd_scan_ctrl_hex_en(hex_en), .ssd_scan_ctrl_bcd_en(bcd_en),
        .ssd_scan_ctrl_sel(sel), .ssd_scan_ctrl_blank_lz(blank_lz),
        .ssd_scan_ctrl_an(an4), .ssd_scan_ctrl_cc(cc4), .ssd_scan_ctrl_digit(dig4),
        .ssd_scan_ctrl_src(src4), .ssd_scan_ctrl_frame_done(fd4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    // Advance the CLK_DIV=0 instance until it shows digit 7 (bounded).
    task automatic to_d7();
        int n = 0;
        while (dig !== 3'd7 && n < 16) begin
            tk();
            n++;
        end
        if (n >= 16) begin
            tests++;
            fails++;
            $display("FAIL to_d7: digit 7 not reached, digit=%0d", dig);
        end
    endtask

    initial begin
        logic [7:0] ea;

        // 1: reset values, then BLANK for one tick before digit 0 lights.
        tk(); tk();
        chk("rst_an", an, 8'hFF);
        chk("rst_cc", cc, 7'h7F);
        chk("rst_fd", fd, 1'b0);
        chk("rst_dig", dig, 3'd0);
        chk("rst_src", src, 1'b0);
        chk("rst4_an", an4, 8'hFF);
        rst_n = 1'b1;
        #1;
        chk("rel_an_blank", an, 8'hFF);
        tk();
        chk("first_an", an, 8'hFE);
        chk("first_cc", cc, 7'h0E);
        chk("first_fd", fd, 1'b0);

        // 2: hex scan across one frame, frame_done once per 8 slots.
        for (int d = 1; d < 8; d++) begin
            tk();
            ea = ~(8'd1 << d);
            chk("scan_an", an, ea);
            chk("scan_cc", cc, exp_cc[d]);
            chk("scan_fd", fd, 1'b0);
        end
        tk();
        chk("wrap_fd", fd, 1'b1);
        chk("wrap_an", an, 8'hFE);
        chk("wrap_cc", cc, 7'h0E);
        tk();
        chk("wrap_fd_clr", fd, 1'b0);
        chk("wrap_dig", dig, 3'd1);

        // 3: sel toggles at digit 3; rest of frame stays hex, then one GUARD slot, then BCD.
        tk(); tk();
        chk("t3_dig", dig, 3'd3);
        sel = 1'b1; bcd_en = 1'b1; bcd_val = 32'h7654_3210;
        for (int d = 4; d < 8; d++) begin
            tk();
            chk("t3_hex_cc", cc, exp_cc[d]);
            chk("t3_hex_src", src, 1'b0);
        end
        tk();
        chk("guard_an", an, 8'hFF);
        chk("guard_fd", fd, 1'b1);
        chk("guard_dig", dig, 3'd0);
        tk();
        chk("bcd_an", an, 8'hFE);
        chk("bcd_cc", cc, 7'h40);
        chk("bcd_src", src, 1'b1);

        // sel pulse that reverts before digit 7: no switch, no guard slot.
        tk(); tk();
        sel = 1'b0;
        tk(); tk(); tk();
        sel = 1'b1;
        tk(); tk();
        chk("pulse_dig", dig, 3'd7);
        tk();
        chk("pulse_an", an, 8'hFE);
        chk("pulse_src", src, 1'b1);

        // 4: leading-zero blanking and BCD out-of-range glyph.
        blank_lz = 1'b1; bcd_val = 32'h0000_0120;
        to_d7();
        tk();
        chk("lz_an0", an, 8'hFE);
        chk("lz_cc0", cc, 7'h40);
        tk();
        chk("lz_an1", an, 8'hFD);
        chk("lz_cc1", cc, 7'h24);
        tk();
        chk("lz_an2", an, 8'hFB);
        chk("lz_cc2", cc, 7'h79);
        for (int d = 3; d < 8; d++) begin
            tk();
            chk("lz_blank_an", an, 8'hFF);
            chk("lz_blank_cc", cc, 7'h7F);
        end
        bcd_val = 32'h0000_0A20;
        tk(); tk(); tk();
        chk("bcd_dash_an", an, 8'hFB);
        chk("bcd_dash_cc", cc, 7'h3F);
        bcd_val = 32'h0;
        to_d7();
        tk();
        chk("lz_zero_an0", an, 8'hFE);
        chk("lz_zero_cc0", cc, 7'h40);
        tk();
        chk("lz_zero_an1", an, 8'hFF);

        // 5: disabled source blanks the whole frame; mid-frame value changes are not shown.
        to_d7();
        sel = 1'b0; hex_en = 1'b0; blank_lz = 1'b0; hex_val = 32'h1234_5678;
        tk();
        chk("t5_guard_an", an, 8'hFF);
        chk("t5_guard_src", src, 1'b1);
        tk();
        chk("t5_src", src, 1'b0);
        chk("t5_off_an0", an, 8'hFF);
        for (int d = 1; d < 8; d++) begin
            tk();
            chk("t5_off_an", an, 8'hFF);
        end
        hex_en = 1'b1;
        tk();
        chk("t5_on_an", an, 8'hFE);
        chk("t5_on_cc", cc, 7'h00);
        tk(); tk(); tk();
        hex_val = 32'hFFFF_FFFF;
        tk();
        chk("t5_snap_dig", dig, 3'd4);
        chk("t5_snap_cc", cc, 7'h19);
        to_d7();
        tk();
        chk("t5_new_cc", cc, 7'h0E);

        // 6: CLK_DIV = 3 instance: 4 clocks per slot, async reset mid-frame.
        hex_val = 32'h89AB_CDEF; sel = 1'b0; hex_en = 1'b1; blank_lz = 1'b0;
        rst4_n = 1'b1;
        tk(); tk(); tk();
        chk("d4_blank_an", an4, 8'hFF);
        tk();
        chk("d4_an0", an4, 8'hFE);
        chk("d4_cc0", cc4, 7'h0E);
        tk(); tk(); tk();
        chk("d4_hold_an", an4, 8'hFE);
        tk();
        chk("d4_an1", an4, 8'hFD);
        repeat (16) tk();
        tk();
        chk("d4_dig5", dig4, 3'd5);
        chk("d4_an5", an4, 8'hDF);
        #2;
        rst4_n = 1'b0;
        #1;
        chk("d4_arst_an", an4, 8'hFF);
        chk("d4_arst_cc", cc4, 7'h7F);
        chk("d4_arst_dig", dig4, 3'd0);
        chk("d4_arst_fd", fd4, 1'b0);
        rst4_n = 1'b1;
        tk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
